// File: rtl/call_request_register.sv
// Elevator call latch: edge-detected hall/car buttons, floor tracking from landing
// sensors, and a combinational next-target selector driven from the latched state.
module call_request_register #(
    parameter int N = 8,
    localparam int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] button_up,
    input  logic [N-1:0] button_down,
    input  logic [N-1:0] button_select_floor,
    input  logic [N-1:0] floor_sensor,
    input  logic         door_open,
    input  logic         direction_up,
    input  logic         direction_down,
    input  logic         fire_alert,
    output logic [N-1:0] up_calls,
    output logic [N-1:0] down_calls,
    output logic [N-1:0] car_calls,
    output logic [W-1:0] current_floor,
    output logic         floor_valid,
    output logic         sensor_error,
    output logic         req_above,
    output logic         req_below,
    output logic         req_here,
    output logic [W-1:0] target_floor,
    output logic         target_valid
);
    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [N-1:0] UP_MASK = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] DN_MASK = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] up_prev_q, up_prev_d, dn_prev_q, dn_prev_d, car_prev_q, car_prev_d;
    logic [N-1:0] up_calls_q, up_calls_d, dn_calls_q, dn_calls_d, car_calls_q, car_calls_d;
    logic [W-1:0] cur_floor_q, cur_floor_d;
    logic         floor_valid_q, floor_valid_d, sensor_error_q, sensor_error_d;

    logic [N-1:0] here_mask, clr_up, clr_dn, clr_car;
    logic         serve, idle, onehot;

    always_comb begin
        idle      = ~direction_up & ~direction_down;
        serve     = door_open & floor_valid_q;
        here_mask = ONE << cur_floor_q;
        clr_car   = serve ? here_mask : '0;
        clr_up    = (serve && (direction_up || idle)) ? here_mask : '0;
        clr_dn    = (serve && (direction_down || idle)) ? here_mask : '0;

        // Prev copies track the buttons even in fire mode so an alert-time press never latches later.
        up_prev_d  = button_up;
        dn_prev_d  = button_down;
        car_prev_d = button_select_floor;

        up_calls_d  = (up_calls_q  | (button_up & ~up_prev_q & UP_MASK))   & ~clr_up;
        dn_calls_d  = (dn_calls_q  | (button_down & ~dn_prev_q & DN_MASK)) & ~clr_dn;
        car_calls_d = (car_calls_q | (button_select_floor & ~car_prev_q))  & ~clr_car;
        if (fire_alert) begin
            up_calls_d  = '0;
            dn_calls_d  = '0;
            car_calls_d = '0;
        end

        cur_floor_d    = cur_floor_q;
        floor_valid_d  = floor_valid_q;
        sensor_error_d = sensor_error_q;
        onehot = (floor_sensor != '0) && ((floor_sensor & (floor_sensor - ONE)) == '0);
        if (onehot) begin
            floor_valid_d = 1'b1;
            for (int i = 0; i < N; i++)
                if (floor_sensor[i]) cur_floor_d = W'(i);
        end else if (floor_sensor != '0) begin
            sensor_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_prev_q      <= '0;
            dn_prev_q      <= '0;
            car_prev_q     <= '0;
            up_calls_q     <= '0;
            dn_calls_q     <= '0;
            car_calls_q    <= '0;
            cur_floor_q    <= '0;
            floor_valid_q  <= 1'b0;
            sensor_error_q <= 1'b0;
        end else begin
            up_prev_q      <= up_prev_d;
            dn_prev_q      <= dn_prev_d;
            car_prev_q     <= car_prev_d;
            up_calls_q     <= up_calls_d;
            dn_calls_q     <= dn_calls_d;
            car_calls_q    <= car_calls_d;
            cur_floor_q    <= cur_floor_d;
            floor_valid_q  <= floor_valid_d;
            sensor_error_q <= sensor_error_d;
        end
    end

    assign up_calls      = up_calls_q;
    assign down_calls    = dn_calls_q;
    assign car_calls     = car_calls_q;
    assign current_floor = cur_floor_q;
    assign floor_valid   = floor_valid_q;
    assign sensor_error  = sensor_error_q;

    logic [N-1:0] pending;
    logic         any_above, any_below, any_here, found_above, gate;
    logic [W-1:0] near_above, near_below;

    // floor_valid is still 0 the cycle after reset, so gating on it plus live rst covers both cycles.
    always_comb begin
        pending     = up_calls_q | dn_calls_q | car_calls_q;
        gate        = floor_valid_q & ~rst;
        any_above   = 1'b0;
        any_below   = 1'b0;
        any_here    = 1'b0;
        found_above = 1'b0;
        near_above  = '0;
        near_below  = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                if (i > int'(cur_floor_q)) begin
                    any_above = 1'b1;
                    if (!found_above) begin
                        near_above  = W'(i);
                        found_above = 1'b1;
                    end
                end else if (i < int'(cur_floor_q)) begin
                    any_below  = 1'b1;
                    near_below = W'(i);
                end else begin
                    any_here = 1'b1;
                end
            end
        end

        req_above    = gate & any_above;
        req_below    = gate & any_below;
        req_here     = gate & any_here;
        target_floor = '0;
        target_valid = 1'b0;
        if (rst) begin
            target_floor = '0;
        end else if (fire_alert) begin
            target_valid = 1'b1;
        end else if (gate) begin
            target_valid = any_above | any_below | any_here;
            if (direction_up && any_above)        target_floor = near_above;
            else if (direction_down && any_below) target_floor = near_below;
            else if (any_here)                    target_floor = cur_floor_q;
            else if (any_above)                   target_floor = near_above;
            else if (any_below)                   target_floor = near_below;
            else                                  target_floor = cur_floor_q;
        end
    end
endmodule
